// File: rtl/score_vram_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : score_vram_writer
//  Description : Avalon-MM master that converts a 20-bit binary score into
//                six decimal glyphs (iterative double-dabble) and writes them
//                as two 32-bit IBM-437 words into text-mode VRAM.
//                Optional build macro SCORE_LZ_BLANK_EN blanks leading zeros
//                among d5..d1.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_vram_writer #(
    parameter int unsigned ROW = 2,     // text row of the score field, 0..29
    parameter int unsigned COL = 68,    // first text column, multiple of 4, 0..72
    parameter bit          INV = 1'b0   // inverse-video bit for every glyph
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [19:0] SCORE,
    output logic        BUSY,
    output logic        DONE,
    output logic [11:0] AVM_ADDR,
    output logic        AVM_WRITE,
    output logic [3:0]  AVM_BYTE_EN,
    output logic [31:0] AVM_WRITEDATA,
    input  logic        AVM_WAITREQUEST
);

    localparam logic [11:0] c_BASE    = 12'(ROW * 20 + COL / 4);
    localparam logic [19:0] c_MAX     = 20'd999999;
    localparam logic [4:0]  c_LAST_IT = 5'd19;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CONV = 3'd1,
        S_PACK = 3'd2,
        S_WR0  = 3'd3,
        S_WR1  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] score_q, score_d;
    logic [19:0] shift_q, shift_d;
    logic [23:0] bcd_q,   bcd_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic        pend_q,  pend_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
    logic [11:0] addr_q,  addr_d;
    logic        we_q,    we_d;
    logic [3:0]  be_q,    be_d;
    logic [31:0] data_q,  data_d;
    logic [31:0] word1_q, word1_d;

    logic [19:0] w_clamped;
    logic [23:0] w_adj;
    logic [5:0]  w_blank;
    logic [7:0]  w_char [6];
    logic [31:0] w_word0;
    logic [31:0] w_word1;

    function automatic logic [7:0] glyph(input logic [3:0] nib);
        return {INV, 7'h30 + {3'b000, nib}};
    endfunction

    localparam logic [7:0] c_SPACE = {INV, 7'h20};

    // Digit-to-glyph packing with optional leading-zero blanking.
    always_comb begin
        w_blank = 6'b000000;
`ifdef SCORE_LZ_BLANK_EN
        w_blank[5] = (bcd_q[23:20] == 4'd0);
        for (int i = 4; i >= 1; i--) begin
            w_blank[i] = w_blank[i+1] & (bcd_q[4*i +: 4] == 4'd0);
        end
`endif
        for (int i = 0; i < 6; i++) begin
            w_char[i] = w_blank[i] ? c_SPACE : glyph(bcd_q[4*i +: 4]);
        end
        // char0 (leftmost, most significant digit) lives in bits 7:0
        w_word0 = {w_char[2], w_char[3], w_char[4], w_char[5]};
        w_word1 = {c_SPACE, c_SPACE, w_char[0], w_char[1]};
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        data_d  = data_q;
        word1_d = word1_q;

        w_clamped = (SCORE > c_MAX) ? c_MAX : SCORE;

        // double-dabble add-3 correction on every nibble >= 5
        for (int i = 0; i < 6; i++) begin
            w_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                         : bcd_q[4*i +: 4];
        end

        // a START during a sequence is remembered and keeps the newest score
        if (START && busy_q) begin
            score_d = w_clamped;
            pend_d  = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    score_d = w_clamped;
                    shift_d = w_clamped;
                    bcd_d   = 24'd0;
                    cnt_d   = 5'd0;
                    busy_d  = 1'b1;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                bcd_d   = {w_adj[22:0], shift_q[19]};
                shift_d = {shift_q[18:0], 1'b0};
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == c_LAST_IT) begin
                    state_d = S_PACK;
                end
            end
            S_PACK: begin
                data_d  = w_word0;
                word1_d = w_word1;
                addr_d  = c_BASE;
                we_d    = 1'b1;
                be_d    = 4'b1111;
                state_d = S_WR0;
            end
            S_WR0: begin
                if (!AVM_WAITREQUEST) begin
                    addr_d  = c_BASE + 12'd1;
                    data_d  = word1_q;
                    state_d = S_WR1;
                end
            end
            S_WR1: begin
                if (!AVM_WAITREQUEST) begin
                    we_d   = 1'b0;
                    be_d   = 4'b0000;
                    done_d = 1'b1;
                    if (pend_q || START) begin
                        // restart straight into conversion with the newest score
                        shift_d = START ? w_clamped : score_q;
                        bcd_d   = 24'd0;
                        cnt_d   = 5'd0;
                        pend_d  = 1'b0;
                        state_d = S_CONV;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            score_q <= 20'd0;
            shift_q <= 20'd0;
            bcd_q   <= 24'd0;
            cnt_q   <= 5'd0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= 12'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            data_q  <= 32'd0;
            word1_q <= 32'd0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            data_q  <= data_d;
            word1_q <= word1_d;
        end
    end

    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign AVM_ADDR      = addr_q;
    assign AVM_WRITE     = we_q;
    assign AVM_BYTE_EN   = be_q;
    assign AVM_WRITEDATA = data_q;

endmodule
`default_nettype wire

// File: tb/tb_score_vram_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_score_vram_writer
//  Description : Self-checking bench for score_vram_writer. Two instances
//                (default placement, and last-row/last-column with inverse
//                video) share stimulus; expected words come from a decimal
//                arithmetic model of the glyph layout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_vram_writer;

    localparam int unsigned A_ROW = 2;
    localparam int unsigned A_COL = 68;
    localparam bit          A_INV = 1'b0;
    localparam int unsigned B_ROW = 29;
    localparam int unsigned B_COL = 72;
    localparam bit          B_INV = 1'b1;
    localparam logic [11:0] A_BASE = 12'(A_ROW * 20 + A_COL / 4);
    localparam logic [11:0] B_BASE = 12'(B_ROW * 20 + B_COL / 4);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        waitreq = 1'b0;
    logic [19:0] score = 20'd0;

    logic        a_busy, a_done, a_write;
    logic [11:0] a_addr;
    logic [3:0]  a_be;
    logic [31:0] a_data;
    logic        b_busy, b_done, b_write;
    logic [11:0] b_addr;
    logic [3:0]  b_be;
    logic [31:0] b_data;

    int checks = 0;
    int errors = 0;
    int n = 0;

    score_vram_writer #(.ROW(A_ROW), .COL(A_COL), .INV(A_INV)) u_dut_a (
        .CLK(clk), .RESET_N(rst_n), .START(start), .SCORE(score),
        .BUSY(a_busy), .DONE(a_done), .AVM_ADDR(a_addr), .AVM_WRITE(a_write),
        .AVM_BYTE_EN(a_be), .AVM_WRITEDATA(a_data), .AVM_WAITREQUEST(waitreq)
    );

    score_vram_writer #(.ROW(B_ROW), .COL(B_COL), .INV(B_INV)) u_dut_b (
        .CLK(clk), .RESET_N(rst_n), .START(start), .SCORE(score),
        .BUSY(b_busy), .DONE(b_done), .AVM_ADDR(b_addr), .AVM_WRITE(b_write),
        .AVM_BYTE_EN(b_be), .AVM_WRITEDATA(b_data), .AVM_WAITREQUEST(waitreq)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: clamp, split into decimal digits, lay out 8 characters.
    function automatic logic [31:0] ref_word(input logic [19:0] sc, input bit inv, input int idx);
        int         v;
        int         d [6];
        logic [7:0] c [8];
`ifdef SCORE_LZ_BLANK_EN
        bit         lead;
        lead = 1'b1;
`endif
        v = (sc > 20'd999999) ? 999999 : int'(sc);
        for (int k = 0; k < 6; k++) begin
            d[k] = v % 10;
            v    = v / 10;
        end
        for (int j = 0; j < 6; j++) begin
            c[j] = 8'h30 + 8'(d[5-j]);
`ifdef SCORE_LZ_BLANK_EN
            if (lead && d[5-j] == 0 && j < 5) c[j] = 8'h20;
            else lead = 1'b0;
`endif
        end
        c[6] = 8'h20;
        c[7] = 8'h20;
        for (int j = 0; j < 8; j++) c[j][7] = inv;
        return {c[idx*4+3], c[idx*4+2], c[idx*4+1], c[idx*4]};
    endfunction

    task automatic tick();
        @(negedge clk);
        n++;
    endtask

    task automatic bus_check(input string tag, input logic [11:0] ea, input logic [31:0] da,
                             input logic [11:0] eb, input logic [31:0] db);
        chk({tag, "_we_a"},   32'(a_write), 32'd1);
        chk({tag, "_addr_a"}, 32'(a_addr),  32'(ea));
        chk({tag, "_data_a"}, a_data,       da);
        chk({tag, "_be_a"},   32'(a_be),    32'hF);
        chk({tag, "_we_b"},   32'(b_write), 32'd1);
        chk({tag, "_addr_b"}, 32'(b_addr),  32'(eb));
        chk({tag, "_data_b"}, b_data,       db);
    endtask

    // One write beat: stall for 'stall' cycles, then let the edge accept it.
    task automatic phase(input string tag, input int stall, input logic [11:0] ea,
                         input logic [31:0] da, input logic [11:0] eb, input logic [31:0] db);
        for (int i = 0; i < stall; i++) begin
            waitreq = 1'b1;
            bus_check(tag, ea, da, eb, db);
            tick();
        end
        waitreq = 1'b0;
        bus_check(tag, ea, da, eb, db);
        tick();
    endtask

    // Called at the negedge right after the start edge (n = 0 there).
    task automatic run_pair(input logic [19:0] sc, input int s0, input int s1, input bit more,
                            input int pend_at, input logic [19:0] psc);
        n = 0;
        while (a_write !== 1'b1 && n < 60) begin
            if (n == pend_at) begin
                start = 1'b1;
                score = psc;
            end
            tick();
            start = 1'b0;
        end
        chk("wr_latency", n, 32'd21);
        phase("w0", s0, A_BASE, ref_word(sc, A_INV, 0), B_BASE, ref_word(sc, B_INV, 0));
        phase("w1", s1, A_BASE + 12'd1, ref_word(sc, A_INV, 1),
              B_BASE + 12'd1, ref_word(sc, B_INV, 1));
        chk("done_a",     32'(a_done),  32'd1);
        chk("done_b",     32'(b_done),  32'd1);
        chk("done_lat",   n,            32'(23 + s0 + s1));
        chk("busy_after", 32'(a_busy),  32'(more));
        chk("we_after",   32'(a_write), 32'd0);
        chk("be_after",   32'(a_be),    32'd0);
    endtask

    task automatic kick(input logic [19:0] sc);
        start = 1'b1;
        score = sc;
        tick();
        start = 1'b0;
        score = 20'($urandom);
        chk("busy_rise", 32'(a_busy),  32'd1);
        chk("we_idle",   32'(a_write), 32'd0);
    endtask

    task automatic txn(input logic [19:0] sc, input int s0, input int s1);
        kick(sc);
        run_pair(sc, s0, s1, 1'b0, -1, 20'd0);
        tick();
        chk("done_pulse", 32'(a_done), 32'd0);
        chk("busy_fall",  32'(a_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(a_busy),  32'd0);
        chk("rst_done", 32'(a_done),  32'd0);
        chk("rst_we",   32'(a_write), 32'd0);
        chk("rst_addr", 32'(a_addr),  32'd0);
        chk("rst_data", a_data,       32'd0);
        chk("rst_be",   32'(a_be),    32'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_we", 32'(a_write), 32'd0);

        // directed values and boundaries
        txn(20'd1234, 0, 0);
        txn(20'd0, 0, 0);
        txn(20'hFFFFF, 0, 0);
        txn(20'd999999, 0, 0);
        txn(20'd1000000, 1, 0);
        txn(20'd1234, 3, 0);
        txn(20'd9, 0, 2);
        txn(20'd100000, 2, 1);

        // restart requested mid-conversion, newest score wins
        kick(20'd5);
        run_pair(20'd5, 0, 0, 1'b1, 9, 20'd77);
        run_pair(20'd77, 0, 0, 1'b0, -1, 20'd0);
        tick();
        chk("pend_done_pulse", 32'(a_done), 32'd0);
        chk("pend_busy_fall",  32'(a_busy), 32'd0);

        // randomized scores and stalls
        for (int t = 0; t < 12; t++) begin
            logic [19:0] rs;
            rs = (t % 3 == 0) ? 20'($urandom_range(0, 999)) : 20'($urandom);
            txn(rs, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // asynchronous reset in the middle of a stalled WR0
        kick(20'd4321);
        n = 0;
        waitreq = 1'b1;
        while (a_write !== 1'b1 && n < 60) tick();
        chk("pre_rst_we", 32'(a_write), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_we_a",   32'(a_write), 32'd0);
        chk("arst_busy_a", 32'(a_busy),  32'd0);
        chk("arst_addr_a", 32'(a_addr),  32'd0);
        chk("arst_data_a", a_data,       32'd0);
        chk("arst_be_a",   32'(a_be),    32'd0);
        chk("arst_we_b",   32'(b_write), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        waitreq = 1'b0;
        seen    = 0;
        repeat (30) begin
            tick();
            if (a_write || b_write || a_busy) seen++;
        end
        chk("no_wr_after_rst", seen, 32'd0);

        txn(20'd42, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/score_vram_writer.md
# score_vram_writer

Avalon-MM master that renders a binary score as decimal glyphs into the text-mode VRAM of the VGA display slave. On a START pulse it clamps the score, converts it to six BCD digits with an iterative double-dabble, and packs the digits into two 32-bit VRAM words of IBM-437 codes. It then writes both words over Avalon-MM, honouring waitrequest. It sits between the game logic and the VGA text-mode slave's VRAM window.

## Interface
- ROW, 2: text row of the score field, 0–29.
- COL, 68: first text column of the field. Must be a multiple of 4, range 0–72.
- INV, 0: value written into the inverse bit (bit 7) of every glyph byte.

- CLK  in  1  system clock, 50 MHz
- RESET_N  in  1  asynchronous, active-low reset
- START  in  1  request pulse. Sampled on every rising CLK edge.
- SCORE  in  20  unsigned binary score. Sampled on the edge where START=1.
- BUSY  out  1  high while a conversion or write sequence is in progress
- DONE  out  1  one-cycle pulse when the second word has been accepted
- AVM_ADDR  out  12  VRAM word address
- AVM_WRITE  out  1  Avalon write request
- AVM_BYTE_EN  out  4  byte enables
- AVM_WRITEDATA  out  32  write data
- AVM_WAITREQUEST  in  1  slave stall

## Operation
- **Base word address:** BASE = ROW*20 + COL/4. It is computed at elaboration and is 12 bits wide. With the defaults, BASE = 57 (0x039).
- **Clamp:** SCORE values above 999999 are replaced by 999999 at capture.
- **State machine:** IDLE → CONV → PACK → WR0 → WR1 → IDLE.
  - IDLE: START=1 captures the clamped score. It loads a 20-bit shift register and zeroes a 24-bit BCD register. Next state is CONV.
  - CONV: runs exactly 20 iterations. Each iteration first adds 3 to every BCD nibble ≥5, then shifts {BCD, bin} left by 1.
  - PACK: forms 8 glyph bytes, each {INV, code[6:0]}.
    - Digit code = 0x30 + nibble. Space = 0x20.
    - Byte order: char0 (leftmost on screen) sits in bits 7:0.
    - Word0 holds d5, d4, d3, d2 (d5 = most significant digit).
    - Word1 holds d1, d0, space, space.
  - WR0: drives AVM_ADDR=BASE, word0 data, AVM_WRITE=1, AVM_BYTE_EN=4'b1111. Stays in WR0 until a CLK edge sees AVM_WAITREQUEST=0.
  - WR1: same as WR0 with AVM_ADDR=BASE+1 and word1 data. On acceptance, DONE=1 for one cycle and the state returns to IDLE.
- **Bus signals outside WR0/WR1:** AVM_WRITE=0, AVM_BYTE_EN=0. AVM_ADDR and AVM_WRITEDATA hold their last values.
- **Signal stability:** address, data and byte enables must not change while AVM_WRITE=1 and AVM_WAITREQUEST=1.
- **START while BUSY:** sets a pending flag and overwrites the captured score with the newest clamped SCORE.
  - On completing WR1 with the flag set: DONE still pulses, the flag clears, and the next state is CONV (not IDLE). BUSY stays high.
  - A START on the same edge that WR1 completes is treated as pending.
- **Reset (RESET_N low, any time, including mid-write):** immediately forces:
  - state = IDLE
  - BUSY, DONE, AVM_WRITE, pending flag = 0
  - AVM_ADDR, AVM_WRITEDATA, AVM_BYTE_EN = 0
  - BCD and shift registers = 0
- **After reset release:** no write is emitted until a new START.

## Timing
- Let E be the edge that samples START=1 in IDLE.
- BUSY rises at edge E.
- CONV occupies 20 cycles and PACK 1 cycle. AVM_WRITE rises at edge E+21.
- With AVM_WAITREQUEST=0 throughout:
  - word0 is accepted at E+22 and word1 at E+23.
  - DONE is high in the cycle after edge E+23.
  - BUSY falls at edge E+23.
- Each cycle of waitrequest asserted during WR0 or WR1 adds one cycle to everything that follows.
- A pending restart enters CONV at the DONE edge. Its first write appears 21 cycles later.
- All outputs are registered.

## Configuration
- **SCORE_LZ_BLANK_EN defined:** during PACK, leading zero digits among d5..d1 become spaces (0x20). Blanking stops at the first non-zero digit. d0 is always shown.
- **SCORE_LZ_BLANK_EN undefined:** all six digits are shown, including leading zeros.
- Timing is identical in both builds.

## Test plan
- SCORE=1234, START pulse, waitrequest 0, macro undefined:
  - write 0x039 ← 0x32313030
  - write 0x03A ← 0x20203433
  - DONE at E+23
- Same stimulus with SCORE_LZ_BLANK_EN defined: 0x039 ← 0x32312020, 0x03A ← 0x20203433.
- SCORE=0 with the macro defined: 0x039 ← 0x20202020, 0x03A ← 0x20203020.
- SCORE=20'hFFFFF, INV=1: clamped to 999999, giving 0x039 ← 0xB9B9B9B9 and 0x03A ← 0xA0A0B9B9.
- AVM_WAITREQUEST held high for 3 cycles on WR0:
  - AVM_ADDR, AVM_WRITEDATA and AVM_WRITE stay stable throughout the stall.
  - DONE moves to E+26.
- Score/reset sequencing:
  - START with SCORE=5, then START with SCORE=77 at E+10: two write pairs are emitted, the second carrying "000077".
  - RESET_N pulsed low during WR0: AVM_WRITE=0 and BUSY=0 immediately, with no further writes.
